// File: rtl/add64_sequencer_pkg.sv
// ============================================================================
// Module   : add64_sequencer_pkg
// Brief    : Shared state encoding and slice geometry for the 64-bit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add64_sequencer_pkg;

   localparam int SLICE_W = 16;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/add64_sequencer_fa16.sv
// ============================================================================
// Module   : FullAdder16bit
// Brief    : 16-bit adder slice with carry in/out, shared by the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module FullAdder16bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        Cout
);

   assign {Cout, S} = {1'b0, A} + {1'b0, B} + {16'd0, Cin};

endmodule

`default_nettype wire

// File: rtl/add64_sequencer.sv
// ============================================================================
// Module   : add64_sequencer
// Brief    : Multi-cycle 64-bit add/subtract, one 16-bit slice per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add64_sequencer
   import add64_sequencer_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SLICE_W*SLICES-1:0] a,
   input  logic [SLICE_W*SLICES-1:0] b,
   input  logic                      cin,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLICE_W*SLICES-1:0] sum,
   output logic                      cout,
   output logic                      overflow
);

   localparam int W = SLICE_W * SLICES;

   state_t               r_state;
   state_t               w_state_next;
   logic [W-1:0]         r_a;
   logic [W-1:0]         r_b_eff;
   logic [W-1:0]         r_sum;
   logic                 r_carry;
   logic                 r_cout;
   logic                 r_ovf;
   logic [IDX_W-1:0]     r_idx;

   logic [SLICE_W-1:0]   w_a_slice;
   logic [SLICE_W-1:0]   w_b_slice;
   logic [SLICE_W-1:0]   w_s;
   logic                 w_c;
   logic                 w_accept;
   logic                 w_last;

   assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
   assign w_b_slice = r_b_eff[r_idx*SLICE_W +: SLICE_W];
   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_last    = (r_idx == IDX_W'(SLICES - 1));

   FullAdder16bit u_slice (
      .A    (w_a_slice),
      .B    (w_b_slice),
      .Cin  (r_carry),
      .S    (w_s),
      .Cout (w_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = RUN;
         end
         RUN: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Subtraction is folded in at accept time: A + ~B + 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b_eff <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b_eff <= sub ? ~b : b;
         r_carry <= sub ? 1'b1 : cin;
         r_idx   <= '0;
      end else if (r_state == RUN) begin
         r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
         r_carry <= w_c;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            r_cout <= w_c;
            r_ovf  <= (r_a[W-1] == r_b_eff[W-1]) && (w_s[SLICE_W-1] != r_a[W-1]);
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

`default_nettype wire
